tx_sched: RTL

Round-robin scheduler sharing the single UART transmitter among up to `N_REQ` level-signalling requesters, for example ALU result, register-file read data and status bytes. It edge-detects each request level into a pending flag, using the same rising-edge rule as the pulse generator. It then launches one byte at a time into the transmitter and tracks the transmitter's busy level to decide when the next launch is allowed. It sits between the system controller's data sources and the UART TX input port.

---
 rtl/tx_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tx_sched.sv
`timescale 1ns/1ps
// tx_sched: round-robin launcher that shares one UART transmitter among N_REQ
// level-signalling requesters, tracking tx_busy and dropping on a busy timeout.
module tx_sched #(
   parameter int DATA_W  = 8,
   parameter int N_REQ   = 4,
   parameter int BUSY_TO = 4
) (
   input  logic                    clk,
   input  logic                    RST,
   input  logic [N_REQ-1:0]        req_lvl,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic                    tx_busy,
   output logic [DATA_W-1:0]       tx_data,
   output logic                    tx_valid,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        pending,
   output logic                    drop
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (BUSY_TO > 0) ? $clog2(BUSY_TO + 1) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LAUNCH  = 2'd1;
   localparam logic [1:0] ST_WAIT_HI = 2'd2;
   localparam logic [1:0] ST_WAIT_LO = 2'd3;

   logic [1:0]        state;
   logic [N_REQ-1:0]  req_q;
   logic [N_REQ-1:0]  rise;
   logic [N_REQ-1:0]  clr;
   logic [N_REQ-1:0]  rot;
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  win_idx;
   logic              win_found;
   logic              launch;
   logic [DATA_W-1:0] win_byte;
   logic [CNT_W-1:0]  cnt;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
      logic [PTR_W-1:0] nxt;
      nxt = idx + PTR_W'(1);
      if (idx == PTR_W'(N_REQ - 1))
         nxt = '0;
      return nxt;
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v = '0;
      for (int i = 0; i < N_REQ; i++)
         if (idx == PTR_W'(i))
            v[i] = 1'b1;
      return v;
   endfunction

   // Rotate pending so bit 0 is the requester at ptr; lowest set bit wins.
   assign rot = N_REQ'({pending, pending} >> ptr);

   always_comb begin
      logic [PTR_W:0] sum;
      win_found = 1'b0;
      win_idx   = '0;
      sum       = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            win_found = 1'b1;
            sum = {1'b0, ptr} + (PTR_W+1)'(j);
            if (sum >= (PTR_W+1)'(N_REQ))
               sum = sum - (PTR_W+1)'(N_REQ);
            win_idx = sum[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      win_byte = '0;
      for (int i = 0; i < N_REQ; i++)
         if (win_idx == PTR_W'(i))
            win_byte = req_data[i*DATA_W +: DATA_W];
   end

   assign rise   = req_lvl & ~req_q;
   assign launch = (state == ST_IDLE) && win_found && !tx_busy;
   assign clr    = launch ? onehot(win_idx) : '0;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state    <= ST_IDLE;
         req_q    <= '0;
         pending  <= '0;
         ptr      <= '0;
         cnt      <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         grant    <= '0;
         drop     <= 1'b0;
      end else begin
         req_q    <= req_lvl;
         // A fresh rise on the granted bit re-arms it in the same cycle.
         pending  <= (pending & ~clr) | rise;
         tx_valid <= 1'b0;
         grant    <= '0;
         drop     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  tx_data  <= win_byte;
                  tx_valid <= 1'b1;
                  grant    <= onehot(win_idx);
                  ptr      <= wrap_inc(win_idx);
                  state    <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               cnt   <= CNT_W'(BUSY_TO);
               state <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (tx_busy) begin
                  state <= ST_WAIT_LO;
               end else if (cnt <= CNT_W'(1)) begin
                  cnt   <= '0;
                  drop  <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               if (!tx_busy)
                  state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
